// File: rtl/sweep_controller.sv
// Radar servo sweep sequencer: steps the position index back and forth and,
// at each position, waits for settling, requests a measurement, then a transmission.
module sweep_controller #(
   parameter int SETTLE_CYCLES  = 50_000_000,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       pronto_medida,
   input  logic       pronto_tx,
   output logic [2:0] posicao,
   output logic       medir,
   output logic       transmitir,
   output logic       direcao,
   output logic       fim_varredura,
   output logic       erro_medida,
   output logic [3:0] db_estado
);

   localparam int MAXC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO     = '0;
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      SETTLE    = 4'd1,
      MEASURE   = 4'd2,
      WAIT_MEAS = 4'd3,
      SEND      = 4'd4,
      WAIT_TX   = 4'd5,
      STEP      = 4'd6
   } state_t;

   state_t        estado, estado_prox;
   logic [CW-1:0] cnt, cnt_prox;
   logic [2:0]    pos_prox;
   logic          dir_prox;
   logic          fim_prox;
   logic          erro_prox;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado        <= IDLE;
         cnt           <= CNT_ZERO;
         posicao       <= 3'd0;
         direcao       <= 1'b0;
         fim_varredura <= 1'b0;
         erro_medida   <= 1'b0;
      end else begin
         estado        <= estado_prox;
         cnt           <= cnt_prox;
         posicao       <= pos_prox;
         direcao       <= dir_prox;
         fim_varredura <= fim_prox;
         erro_medida   <= erro_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      cnt_prox    = cnt;
      pos_prox    = posicao;
      dir_prox    = direcao;
      fim_prox    = 1'b0;
      erro_prox   = erro_medida;
      case (estado)
         IDLE: begin
            cnt_prox = CNT_ZERO;
            if (ligar) estado_prox = SETTLE;
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               estado_prox = MEASURE;
               cnt_prox    = CNT_ZERO;
            end else begin
               cnt_prox = cnt + CNT_ONE;
            end
         end
         MEASURE: begin
            erro_prox   = 1'b0;
            cnt_prox    = CNT_ZERO;
            estado_prox = WAIT_MEAS;
         end
         WAIT_MEAS: begin
            // A response on the timeout cycle still counts as a good measurement.
            if (pronto_medida) begin
               estado_prox = SEND;
               cnt_prox    = CNT_ZERO;
            end else if (cnt == TIMEOUT_LAST) begin
               erro_prox   = 1'b1;
               estado_prox = SEND;
               cnt_prox    = CNT_ZERO;
            end else begin
               cnt_prox = cnt + CNT_ONE;
            end
         end
         SEND: estado_prox = WAIT_TX;
         WAIT_TX: begin
            if (pronto_tx) estado_prox = STEP;
         end
         STEP: begin
            cnt_prox = CNT_ZERO;
            // Endpoints turn around in place so each endpoint is visited once per pass.
            if (!direcao) begin
               if (posicao == 3'd7) begin
                  pos_prox = 3'd6;
                  dir_prox = 1'b1;
                  fim_prox = 1'b1;
               end else begin
                  pos_prox = posicao + 3'd1;
               end
            end else begin
               if (posicao == 3'd0) begin
                  pos_prox = 3'd1;
                  dir_prox = 1'b0;
                  fim_prox = 1'b1;
               end else begin
                  pos_prox = posicao - 3'd1;
               end
            end
            estado_prox = ligar ? SETTLE : IDLE;
         end
         default: estado_prox = IDLE;
      endcase
   end

   assign medir      = (estado == MEASURE);
   assign transmitir = (estado == SEND);
   assign db_estado  = estado;

endmodule

// File: tb/tb_sweep_controller.sv
// Randomized bench for sweep_controller; expected positions come from the ping-pong
// sweep rule (visit number modulo 14) and state timing from the dwell/timeout rules.
module tb_sweep_controller;

   localparam int S = 4;
   localparam int T = 8;

   logic       clock = 1'b0;
   logic       reset, ligar, pronto_medida, pronto_tx;
   logic [2:0] posicao;
   logic       medir, transmitir, direcao, fim_varredura, erro_medida;
   logic [3:0] db_estado;

   int total = 0;
   int bad = 0;
   int k = 0;
   int visits = 0;
   int medir_seen = 0;
   int fim_seen = 0;
   int fim_exp = 0;
   logic [2:0] exp_q[$];

   sweep_controller #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset), .ligar(ligar),
      .pronto_medida(pronto_medida), .pronto_tx(pronto_tx),
      .posicao(posicao), .medir(medir), .transmitir(transmitir),
      .direcao(direcao), .fim_varredura(fim_varredura),
      .erro_medida(erro_medida), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Visit k of the sweep: positions 0..7,6..1 repeat with period 14.
   function automatic logic [2:0] exp_pos(input int kk);
      int p;
      p = kk % 14;
      return (p <= 7) ? 3'(p) : 3'(14 - p);
   endfunction

   function automatic logic exp_dir(input int kk);
      int p;
      p = kk % 14;
      return (p >= 8) || (p == 0 && kk > 0);
   endfunction

   function automatic logic turns_after(input int kk);
      int p;
      p = kk % 14;
      return (p == 7) || (p == 0 && kk > 0);
   endfunction

   always @(negedge clock) begin
      if (reset === 1'b0 && medir === 1'b1) begin
         medir_seen++;
         check("medir_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("medir_pos", posicao, exp_q.pop_front());
      end
      if (reset === 1'b0 && fim_varredura === 1'b1) fim_seen++;
   end

   task automatic visit(input bit force_stop, input bit reset_at_send);
      logic [2:0] p0;
      logic       d0;
      int         d, w, n;
      bit         timeout, stop;
      p0 = exp_pos(k);
      d0 = exp_dir(k);
      visits++;
      exp_q.push_back(p0);
      for (int i = 0; i < S; i++) begin
         check("settle_state", db_estado, 1);
         check("settle_pos", posicao, p0);
         check("settle_dir", direcao, d0);
         check("settle_medir", medir, 0);
         if (i == 1) check("fim_one_cycle", fim_varredura, 0);
         pronto_medida = 1'($urandom_range(0, 1));
         ligar = 1'($urandom_range(0, 1));
         tick();
      end
      check("measure_state", db_estado, 2);
      check("measure_medir", medir, 1);
      check("measure_tx", transmitir, 0);
      pronto_medida = 1'($urandom_range(0, 1));
      ligar = 1'b1;
      tick();
      timeout = ($urandom_range(0, 3) == 0);
      d = timeout ? T : $urandom_range(0, T - 1);
      if (k % 5 == 3) begin
         timeout = 1'b0;
         d = T - 1;
      end
      stop = force_stop || ($urandom_range(0, 5) == 0);
      for (int j = 0; j < T; j++) begin
         check("wait_meas_state", db_estado, 3);
         check("wait_meas_medir", medir, 0);
         if (j == 0 && stop) ligar = 1'b0;
         pronto_medida = (j == d);
         tick();
         if (j == d) break;
      end
      pronto_medida = 1'b0;
      check("send_state", db_estado, 4);
      check("send_tx", transmitir, 1);
      check("erro_medida", erro_medida, 32'(timeout));
      if (reset_at_send) begin
         check("pre_reset_pos", posicao, 5);
         check("pre_reset_dir", direcao, 1);
         #1 reset = 1'b1;
         #1;
         check("async_medir", medir, 0);
         check("async_tx", transmitir, 0);
         check("async_fim", fim_varredura, 0);
         check("async_erro", erro_medida, 0);
         check("async_pos", posicao, 0);
         check("async_dir", direcao, 0);
         check("async_state", db_estado, 0);
         ligar = 1'b0;
         pronto_tx = 1'b0;
         tick();
         tick();
         reset = 1'b0;
         k = 0;
         return;
      end
      pronto_tx = 1'($urandom_range(0, 1));
      tick();
      w = (k == 2) ? 100 : $urandom_range(0, 6);
      pronto_tx = 1'b0;
      for (int j = 0; j < w; j++) begin
         check("wait_tx_state", db_estado, 5);
         check("wait_tx_tx", transmitir, 0);
         tick();
      end
      check("wait_tx_state", db_estado, 5);
      pronto_tx = 1'b1;
      tick();
      pronto_tx = 1'b0;
      check("step_state", db_estado, 6);
      check("step_pos", posicao, p0);
      tick();
      check("fim", fim_varredura, 32'(turns_after(k)));
      if (turns_after(k)) fim_exp++;
      k++;
      check("next_pos", posicao, exp_pos(k));
      check("next_dir", direcao, exp_dir(k));
      if (stop) begin
         n = $urandom_range(1, 5);
         for (int j = 0; j < n; j++) begin
            check("idle_state", db_estado, 0);
            check("idle_pos", posicao, exp_pos(k));
            tick();
         end
         ligar = 1'b1;
         tick();
         check("resume_state", db_estado, 1);
         check("resume_pos", posicao, exp_pos(k));
      end else begin
         check("resettle_state", db_estado, 1);
      end
   endtask

   initial begin
      reset = 1'b1;
      ligar = 1'b0;
      pronto_medida = 1'b0;
      pronto_tx = 1'b0;
      tick();
      tick();
      check("reset_state", db_estado, 0);
      check("reset_pos", posicao, 0);
      check("reset_dir", direcao, 0);
      check("reset_medir", medir, 0);
      check("reset_tx", transmitir, 0);
      check("reset_fim", fim_varredura, 0);
      check("reset_erro", erro_medida, 0);
      reset = 1'b0;
      tick();
      check("idle_no_ligar", db_estado, 0);
      tick();
      check("idle_no_ligar", db_estado, 0);
      ligar = 1'b1;
      tick();
      check("start_state", db_estado, 1);
      check("start_pos", posicao, 0);
      while (!(k >= 30 && k % 14 == 9)) visit(k == 3, 1'b0);
      visit(1'b0, 1'b1);
      check("medir_count", medir_seen, visits);
      check("fim_count", fim_seen, fim_exp);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
